// File: rtl/tpu_drain_pkg.sv
// Shared defaults, derived widths and serializer state encoding for the TPU result drain.
package tpu_drain_pkg;

  // Index width that stays legal when a count collapses to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ARRAY_SIZE        = 8;
  localparam int DEF_OUTPUT_DATA_WIDTH = 16;
  localparam int DEF_OUT_BUS_WIDTH     = 32;
  localparam int DEF_FIFO_DEPTH        = 4;
  localparam int DEF_ADDR_WIDTH        = 6;

  localparam int ROW_W      = DEF_ARRAY_SIZE * DEF_OUTPUT_DATA_WIDTH;
  localparam int BEATS      = ROW_W / DEF_OUT_BUS_WIDTH;
  localparam int BEAT_IDX_W = idx_width(BEATS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/tpu_result_fifo.sv
// Synchronous row FIFO with extra wrap bit on each pointer; read data is the head entry, combinational.
// Zero latency to head; a push while full is taken only when a pop happens in the same cycle.
module tpu_result_fifo
  import tpu_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = idx_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dat     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Captures TPU result rows into a FIFO and serializes each row into bus beats; RESULT_RELU_EN clamps negative lanes at capture.
// Latency: row captured at edge t appears as beat 0 after edge t+1 (FIFO empty, serializer idle); 1 beat/cycle sustained.
// Backpressure: beat held stable while out_ready is low; rows arriving with the FIFO full and no pop are dropped (sticky overflow).
module tpu_result_drain
  import tpu_drain_pkg::*;
#(
  parameter int ARRAY_SIZE        = DEF_ARRAY_SIZE,
  parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
  parameter int OUT_BUS_WIDTH     = DEF_OUT_BUS_WIDTH,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  localparam int ROW_BITS         = ARRAY_SIZE * OUTPUT_DATA_WIDTH,
  localparam int NUM_BEATS        = ROW_BITS / OUT_BUS_WIDTH,
  localparam int BIDX_W           = idx_width(NUM_BEATS)
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic                     row_wen_n,
  input  logic [ROW_BITS-1:0]      row_wdata,
  input  logic [ADDR_WIDTH-1:0]    row_waddr,
  input  logic                     tpu_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_BUS_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [BIDX_W-1:0]        out_beat,
  output logic                     out_last,
  output logic                     overflow,
  output logic                     drain_done
);

  localparam int ENT_W = ADDR_WIDTH + ROW_BITS;
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NUM_BEATS - 1);

  logic [ROW_BITS-1:0]   w_row_cap;
  logic [ENT_W-1:0]      w_fifo_rd;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_wr_req;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_clear;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ROW_BITS-1:0]   r_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BIDX_W-1:0]     r_beat;
  logic                  r_overflow;
  logic                  r_done_seen;
  logic                  r_drain_done;

`ifdef RESULT_RELU_EN
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_relu
    assign w_row_cap[g*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
      row_wdata[g*OUTPUT_DATA_WIDTH + OUTPUT_DATA_WIDTH - 1] ? '0
                                                             : row_wdata[g*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
  end
`else
  assign w_row_cap = row_wdata;
`endif

  // A full FIFO still accepts a row when the serializer pops in the same cycle.
  assign w_wr_req = ~row_wen_n;
  assign w_push   = w_wr_req & (~w_fifo_full | w_pop);
  assign w_drop   = w_wr_req & w_fifo_full & ~w_pop;

  tpu_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srstn   (srstn),
    .i_push  (w_push),
    .i_dat   ({row_waddr, w_row_cap}),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_rd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (r_beat == LAST_BEAT) begin
            if (!w_fifo_empty) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_clear     = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registers are zeroed on return to idle so the bus reads 0 between rows.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_shift <= '0;
      r_addr  <= '0;
      r_beat  <= '0;
    end else if (w_load) begin
      r_shift <= w_fifo_rd[ROW_BITS-1:0];
      r_addr  <= w_fifo_rd[ENT_W-1 -: ADDR_WIDTH];
      r_beat  <= '0;
    end else if (w_adv) begin
      r_shift <= r_shift >> OUT_BUS_WIDTH;
      r_beat  <= r_beat + BIDX_W'(1);
    end else if (w_clear) begin
      r_shift <= '0;
      r_addr  <= '0;
      r_beat  <= '0;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_overflow   <= 1'b0;
      r_done_seen  <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_overflow   <= r_overflow | w_drop;
      r_done_seen  <= r_done_seen | tpu_done;
      r_drain_done <= (r_done_seen | tpu_done) & w_fifo_empty & (r_state == ST_IDLE) & row_wen_n;
    end
  end

  assign out_valid  = (r_state == ST_SEND);
  assign out_data   = r_shift[OUT_BUS_WIDTH-1:0];
  assign out_addr   = r_addr;
  assign out_beat   = r_beat;
  assign out_last   = out_valid & (r_beat == LAST_BEAT);
  assign overflow   = r_overflow;
  assign drain_done = r_drain_done;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed bench for tpu_result_drain: inputs driven and outputs sampled on the falling clock edge.
module tb_tpu_result_drain;

  logic         clk = 1'b0;
  logic         srstn = 1'b0;
  logic         row_wen_n = 1'b1;
  logic [127:0] row_wdata = '0;
  logic [5:0]   row_waddr = '0;
  logic         tpu_done = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [5:0]   out_addr;
  logic [1:0]   out_beat;
  logic         out_last;
  logic         overflow;
  logic         drain_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tpu_result_drain dut (
    .clk        (clk),
    .srstn      (srstn),
    .row_wen_n  (row_wen_n),
    .row_wdata  (row_wdata),
    .row_waddr  (row_waddr),
    .tpu_done   (tpu_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_beat   (out_beat),
    .out_last   (out_last),
    .overflow   (overflow),
    .drain_done (drain_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row whose lane i holds base+i.
  function automatic logic [127:0] ramp(input logic [15:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
    return r;
  endfunction

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic [5:0] a, input int k);
    check($sformatf("%s.b%0d.valid", tag, k), 128'(out_valid), 128'(1));
    check($sformatf("%s.b%0d.data", tag, k), 128'(out_data), 128'(d));
    check($sformatf("%s.b%0d.addr", tag, k), 128'(out_addr), 128'(a));
    check($sformatf("%s.b%0d.beat", tag, k), 128'(out_beat), 128'(k));
    check($sformatf("%s.b%0d.last", tag, k), 128'(out_last), 128'(k == 3));
  endtask

  // Consumes one whole row with out_ready high, one beat per cycle.
  task automatic drain_row(input string tag, input logic [15:0] base, input logic [5:0] a);
    for (int k = 0; k < 4; k++) begin
      chk_beat(tag, {base + 16'(2*k+1), base + 16'(2*k)}, a, k);
      @(negedge clk);
    end
  endtask

  task automatic write_row(input logic [15:0] base, input logic [5:0] a);
    row_wen_n = 1'b0;
    row_wdata = ramp(base);
    row_waddr = a;
    @(negedge clk);
    row_wen_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, ".valid"}, 128'(out_valid), 128'(0));
    check({tag, ".data"}, 128'(out_data), 128'(0));
    check({tag, ".addr"}, 128'(out_addr), 128'(0));
    check({tag, ".beat"}, 128'(out_beat), 128'(0));
    check({tag, ".last"}, 128'(out_last), 128'(0));
    check({tag, ".ovf"}, 128'(overflow), 128'(0));
    check({tag, ".dd"}, 128'(drain_done), 128'(0));
  endtask

  initial begin
    int           seen;
    logic [127:0] rr;
    logic [31:0]  exp_b0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    srstn = 1'b1;
    @(negedge clk);

    // 1: single row, exact beat layout and one-cycle capture-to-valid latency.
    out_ready = 1'b1;
    write_row(16'h0001, 6'd5);
    check("t1.latency", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk_beat("t1", 32'h0002_0001, 6'd5, 0); @(negedge clk);
    chk_beat("t1", 32'h0004_0003, 6'd5, 1); @(negedge clk);
    chk_beat("t1", 32'h0006_0005, 6'd5, 2); @(negedge clk);
    chk_beat("t1", 32'h0008_0007, 6'd5, 3); @(negedge clk);
    check("t1.idle", 128'(out_valid), 128'(0));
    check("t1.idle_data", 128'(out_data), 128'(0));

    // 2: back-pressure on beat 1 for three cycles.
    write_row(16'h0011, 6'd9);
    @(negedge clk);
    chk_beat("t2", 32'h0012_0011, 6'd9, 0); @(negedge clk);
    chk_beat("t2", 32'h0014_0013, 6'd9, 1);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_beat("t2.hold", 32'h0014_0013, 6'd9, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("t2", 32'h0016_0015, 6'd9, 2); @(negedge clk);
    chk_beat("t2", 32'h0018_0017, 6'd9, 3); @(negedge clk);
    check("t2.idle", 128'(out_valid), 128'(0));

    // 3: burst while stalled; the serializer holds one row beyond the FIFO depth, so the sixth row is dropped.
    out_ready = 1'b0;
    for (int r = 0; r < 6; r++) begin
      row_wen_n = 1'b0;
      row_wdata = ramp(16'(r << 8));
      row_waddr = 6'(10 + r);
      @(negedge clk);
    end
    row_wen_n = 1'b1;
    check("t3.overflow", 128'(overflow), 128'(1));
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) drain_row($sformatf("t3.r%0d", r), 16'(r << 8), 6'(10 + r));
    check("t3.idle", 128'(out_valid), 128'(0));
    check("t3.ovf_sticky", 128'(overflow), 128'(1));

    srstn = 1'b0;
    @(negedge clk);
    srstn = 1'b1;
    check("rst2.ovf", 128'(overflow), 128'(0));

    // 4: push lands on the cycle the last beat hands off with the FIFO full.
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      row_wen_n = 1'b0;
      row_wdata = ramp(16'h2000 + 16'(r << 8));
      row_waddr = 6'(20 + r);
      @(negedge clk);
    end
    row_wen_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_beat("t4.r0", {16'h2000 + 16'(2*k+1), 16'h2000 + 16'(2*k)}, 6'd20, k);
      @(negedge clk);
    end
    chk_beat("t4.r0", 32'h2007_2006, 6'd20, 3);
    row_wen_n = 1'b0;
    row_wdata = ramp(16'h2500);
    row_waddr = 6'd25;
    @(negedge clk);
    row_wen_n = 1'b1;
    check("t4.no_ovf", 128'(overflow), 128'(0));
    for (int r = 1; r < 6; r++) drain_row($sformatf("t4.r%0d", r), 16'h2000 + 16'(r << 8), 6'(20 + r));
    check("t4.idle", 128'(out_valid), 128'(0));
    check("t4.no_ovf_end", 128'(overflow), 128'(0));

    // 5: tpu_done pulse with two rows outstanding.
    out_ready = 1'b0;
    row_wen_n = 1'b0;
    row_wdata = ramp(16'h3000);
    row_waddr = 6'd30;
    @(negedge clk);
    row_wdata = ramp(16'h3100);
    row_waddr = 6'd31;
    @(negedge clk);
    row_wen_n = 1'b1;
    tpu_done  = 1'b1;
    @(negedge clk);
    tpu_done  = 1'b0;
    check("t5.dd_busy", 128'(drain_done), 128'(0));
    out_ready = 1'b1;
    drain_row("t5.r0", 16'h3000, 6'd30);
    check("t5.dd_mid", 128'(drain_done), 128'(0));
    drain_row("t5.r1", 16'h3100, 6'd31);
    check("t5.dd_lag", 128'(drain_done), 128'(0));
    check("t5.idle", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("t5.dd_set", 128'(drain_done), 128'(1));

    // 6: reset asserted while beat 2 is on the bus.
    write_row(16'h4000, 6'd40);
    repeat (3) @(negedge clk);
    check("t6.pre_beat", 128'(out_beat), 128'(2));
    srstn = 1'b0;
    #1;
    chk_all_zero("t6.rst");
    @(negedge clk);
    srstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t6.no_beats", 128'(seen), 128'(0));
    check("t6.dd_clr", 128'(drain_done), 128'(0));

    // 7: capture of a negative and a positive lane.
    rr = '0;
    rr[15:0]  = 16'hFFF0;
    rr[31:16] = 16'h0010;
    row_wen_n = 1'b0;
    row_wdata = rr;
    row_waddr = 6'd7;
    @(negedge clk);
    row_wen_n = 1'b1;
    @(negedge clk);
`ifdef RESULT_RELU_EN
    exp_b0 = 32'h0010_0000;
`else
    exp_b0 = 32'h0010_FFF0;
`endif
    chk_beat("t7", exp_b0, 6'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
